// File: rtl/msrv32_ahb_pkg.sv
// Shared definitions for the msrv32 AHB-Lite data-memory bridge.
// Contents: HTRANS and HSIZE encodings and the bridge FSM state type.
package msrv32_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_ERR  = 2'b11
  } ahb_state_t;

endpackage

// File: rtl/msrv32_ahb_size_dec.sv
// Byte-lane mask decoder for the AHB data-memory bridge.
// Ports:
//   mask   in  [3:0] byte-lane mask from the core
//   hsize  out [2:0] AHB transfer size
//   offset out [1:0] byte offset placed in haddr[1:0]
//   legal  out       mask maps onto a single naturally aligned AHB transfer
module msrv32_ahb_size_dec
  import msrv32_ahb_pkg::*;
(
  input  logic [3:0] mask,
  output logic [2:0] hsize,
  output logic [1:0] offset,
  output logic       legal
);

  always_comb begin
    hsize  = HSIZE_BYTE;
    offset = 2'd0;
    legal  = 1'b1;
    case (mask)
      4'b1111: hsize = HSIZE_WORD;
      4'b0011: hsize = HSIZE_HALF;
      4'b1100: begin
        hsize  = HSIZE_HALF;
        offset = 2'd2;
      end
      4'b0001: offset = 2'd0;
      4'b0010: offset = 2'd1;
      4'b0100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/msrv32_ahb_dmem_bridge.sv
// Data-memory bridge: turns one core load/store into one AHB-Lite NONSEQ
// transfer, handling HREADY wait states and the two-cycle ERROR response.
// One transfer is outstanding at a time; every output is registered.
// Optional feature: define MSRV32_AHB_TIMEOUT_EN to abort a data phase that
// stays in wait states for TIMEOUT_CYCLES cycles (done+err reported).
// Ports:
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, async active-high reset
//   core_req_in, core_wr_in, core_addr_in, core_wdata_in, core_mask_in : request
//   core_rdata_out, core_done_out, core_err_out, core_stall_out        : response
//   ahb_haddr_out, ahb_hwrite_out, ahb_hsize_out, ahb_htrans_out,
//   ahb_hwdata_out                                                      : AHB master
//   ahb_hrdata_in, ahb_ready_in, ahb_resp_in                            : AHB slave reply
module msrv32_ahb_dmem_bridge
  import msrv32_ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        core_req_in,
  input  logic        core_wr_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  input  logic [3:0]  core_mask_in,
  output logic [31:0] core_rdata_out,
  output logic        core_done_out,
  output logic        core_err_out,
  output logic        core_stall_out,
  output logic [31:0] ahb_haddr_out,
  output logic        ahb_hwrite_out,
  output logic [2:0]  ahb_hsize_out,
  output logic [1:0]  ahb_htrans_out,
  output logic [31:0] ahb_hwdata_out,
  input  logic [31:0] ahb_hrdata_in,
  input  logic        ahb_ready_in,
  input  logic        ahb_resp_in
);

  logic clk;
  logic rst;
  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  ahb_state_t state_q, state_d;

  logic [2:0]  dec_hsize;
  logic [1:0]  dec_offset;
  logic        dec_legal;
  logic        accept;
  logic        timeout_hit;
  logic [31:0] wdata_q;

  logic [31:0] haddr_d, hwdata_d, rdata_d;
  logic        hwrite_d, done_d, err_d, stall_d;
  logic [2:0]  hsize_d;
  logic [1:0]  htrans_d;

  msrv32_ahb_size_dec u_size_dec (
    .mask   (core_mask_in),
    .hsize  (dec_hsize),
    .offset (dec_offset),
    .legal  (dec_legal)
  );

  // The core keeps req high during the done cycle; gating on done stops the
  // finished request from being taken a second time.
  assign accept = (state_q == ST_IDLE) && core_req_in && !core_done_out;

`ifdef MSRV32_AHB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Fires on the wait cycle that would bring the count up to the limit.
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_ADDR && ahb_ready_in) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_DATA && !ahb_ready_in) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Store data is only needed once the data phase starts; no reset required.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_q <= core_wdata_in;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // Illegal masks never leave IDLE; they are answered with done+err.
        if (accept && dec_legal) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (ahb_ready_in) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ahb_ready_in)     state_d = ST_IDLE;
        else if (ahb_resp_in) state_d = ST_ERR;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (ahb_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    haddr_d  = ahb_haddr_out;
    hwrite_d = ahb_hwrite_out;
    hsize_d  = ahb_hsize_out;
    htrans_d = ahb_htrans_out;
    hwdata_d = ahb_hwdata_out;
    rdata_d  = core_rdata_out;
    done_d   = 1'b0;
    err_d    = 1'b0;
    stall_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            haddr_d  = {core_addr_in[31:2], dec_offset};
            hwrite_d = core_wr_in;
            hsize_d  = dec_hsize;
            htrans_d = HTRANS_NONSEQ;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (ahb_ready_in) begin
          htrans_d = HTRANS_IDLE;
          hwdata_d = wdata_q;
        end
      end
      ST_DATA: begin
        if (ahb_ready_in) begin
          // ready with resp=1 here is a slave protocol slip; report it as an error.
          done_d = 1'b1;
          err_d  = ahb_resp_in;
          if (!ahb_resp_in && !ahb_hwrite_out) rdata_d = ahb_hrdata_in;
        end else if (!ahb_resp_in && timeout_hit) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      ST_ERR: begin
        if (ahb_ready_in) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ahb_haddr_out  <= '0;
      ahb_hwrite_out <= 1'b0;
      ahb_hsize_out  <= '0;
      ahb_htrans_out <= HTRANS_IDLE;
      ahb_hwdata_out <= '0;
      core_rdata_out <= '0;
      core_done_out  <= 1'b0;
      core_err_out   <= 1'b0;
      core_stall_out <= 1'b0;
    end else begin
      ahb_haddr_out  <= haddr_d;
      ahb_hwrite_out <= hwrite_d;
      ahb_hsize_out  <= hsize_d;
      ahb_htrans_out <= htrans_d;
      ahb_hwdata_out <= hwdata_d;
      core_rdata_out <= rdata_d;
      core_done_out  <= done_d;
      core_err_out   <= err_d;
      core_stall_out <= stall_d;
    end
  end

endmodule

// File: tb/tb_msrv32_ahb_dmem_bridge.sv
// Directed testbench for msrv32_ahb_dmem_bridge. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_msrv32_ahb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        done, err, stall;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hrdata = '0;
  logic        ready = 1'b1;
  logic        resp = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msrv32_ahb_dmem_bridge #(
`ifdef MSRV32_AHB_TIMEOUT_EN
    .TIMEOUT_CYCLES(4)
`else
    .TIMEOUT_CYCLES(255)
`endif
  ) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .core_req_in          (req),
    .core_wr_in           (wr),
    .core_addr_in         (addr),
    .core_wdata_in        (wdata),
    .core_mask_in         (mask),
    .core_rdata_out       (rdata),
    .core_done_out        (done),
    .core_err_out         (err),
    .core_stall_out       (stall),
    .ahb_haddr_out        (haddr),
    .ahb_hwrite_out       (hwrite),
    .ahb_hsize_out        (hsize),
    .ahb_htrans_out       (htrans),
    .ahb_hwdata_out       (hwdata),
    .ahb_hrdata_in        (hrdata),
    .ahb_ready_in         (ready),
    .ahb_resp_in          (resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    req = 1'b1; wr = w; addr = a; wdata = d; mask = m;
  endtask

  initial begin
    // Reset values
    #1;
    check("rst_htrans", 32'(htrans), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_haddr", haddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word load, zero wait
    drive_req(1'b0, 32'h0000_1000, 32'h0, 4'b1111);
    @(negedge clk);
    check("t1_htrans_a", 32'(htrans), 32'h2);
    check("t1_haddr", haddr, 32'h0000_1000);
    check("t1_hsize", 32'(hsize), 32'h2);
    check("t1_hwrite", 32'(hwrite), 32'h0);
    check("t1_stall", 32'(stall), 32'h1);
    @(negedge clk);
    check("t1_htrans_d", 32'(htrans), 32'h0);
    check("t1_done_early", 32'(done), 32'h0);
    hrdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_done", 32'(done), 32'h1);
    check("t1_err", 32'(err), 32'h0);
    check("t1_rdata", rdata, 32'hDEAD_BEEF);
    check("t1_stall_end", 32'(stall), 32'h0);
    req = 1'b0; hrdata = '0;
    @(negedge clk);
    check("t1_done_drop", 32'(done), 32'h0);

    // Byte store, two data wait states
    drive_req(1'b1, 32'h0000_2000, 32'h00AB_0000, 4'b0100);
    @(negedge clk);
    check("t2_haddr", haddr, 32'h0000_2002);
    check("t2_hsize", 32'(hsize), 32'h0);
    check("t2_hwrite", 32'(hwrite), 32'h1);
    check("t2_htrans_a", 32'(htrans), 32'h2);
    @(negedge clk);
    check("t2_hwdata", hwdata, 32'h00AB_0000);
    check("t2_htrans_d", 32'(htrans), 32'h0);
    ready = 1'b0;
    @(negedge clk);
    check("t2_wait_done", 32'(done), 32'h0);
    check("t2_wait_stall", 32'(stall), 32'h1);
    @(negedge clk);
    check("t2_wait2_done", 32'(done), 32'h0);
    ready = 1'b1;
    @(negedge clk);
    check("t2_done", 32'(done), 32'h1);
    check("t2_err", 32'(err), 32'h0);
    check("t2_rdata_keep", rdata, 32'hDEAD_BEEF);
    req = 1'b0;
    @(negedge clk);
    check("t2_done_drop", 32'(done), 32'h0);

    // Load with ERROR response, then next request accepted
    drive_req(1'b0, 32'h0000_3000, 32'h0, 4'b1111);
    @(negedge clk);
    check("t3_htrans_a", 32'(htrans), 32'h2);
    @(negedge clk);
    resp = 1'b1; ready = 1'b0;
    @(negedge clk);
    check("t3_err_beat1_done", 32'(done), 32'h0);
    check("t3_err_beat1_stall", 32'(stall), 32'h1);
    ready = 1'b1;
    @(negedge clk);
    check("t3_done", 32'(done), 32'h1);
    check("t3_err", 32'(err), 32'h1);
    resp = 1'b0;
    drive_req(1'b0, 32'h0000_4000, 32'h0, 4'b1100);
    @(negedge clk);
    check("t3_no_accept_in_done", 32'(htrans), 32'h0);
    check("t3_err_clear", 32'(err), 32'h0);
    @(negedge clk);
    check("t3b_htrans", 32'(htrans), 32'h2);
    check("t3b_haddr", haddr, 32'h0000_4002);
    check("t3b_hsize", 32'(hsize), 32'h1);
    @(negedge clk);
    hrdata = 32'h1234_5678;
    @(negedge clk);
    check("t3b_done", 32'(done), 32'h1);
    check("t3b_err", 32'(err), 32'h0);
    check("t3b_rdata", rdata, 32'h1234_5678);
    req = 1'b0; hrdata = '0;
    @(negedge clk);

    // Illegal mask
    drive_req(1'b0, 32'h0000_5000, 32'h0, 4'b0110);
    @(negedge clk);
    check("t4_htrans", 32'(htrans), 32'h0);
    check("t4_done", 32'(done), 32'h1);
    check("t4_err", 32'(err), 32'h1);
    check("t4_stall", 32'(stall), 32'h0);
    req = 1'b0;
    @(negedge clk);
    check("t4_done_drop", 32'(done), 32'h0);

    // Address-phase wait state on a byte store
    drive_req(1'b1, 32'h0000_6000, 32'h0000_00CD, 4'b0001);
    @(negedge clk);
    check("t5_htrans_a", 32'(htrans), 32'h2);
    ready = 1'b0;
    @(negedge clk);
    check("t5_htrans_hold", 32'(htrans), 32'h2);
    check("t5_haddr_hold", haddr, 32'h0000_6000);
    ready = 1'b1;
    @(negedge clk);
    check("t5_htrans_d", 32'(htrans), 32'h0);
    check("t5_hwdata", hwdata, 32'h0000_00CD);
    @(negedge clk);
    check("t5_done", 32'(done), 32'h1);
    req = 1'b0;
    @(negedge clk);

    // Reset during a stalled data phase
    drive_req(1'b0, 32'h0000_7000, 32'h0, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check("t6_stall_pre", 32'(stall), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_stall", 32'(stall), 32'h0);
    check("t6_rst_htrans", 32'(htrans), 32'h0);
    check("t6_rst_haddr", haddr, 32'h0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_done", 32'(done), 32'h0);
      check("t6_idle_stall", 32'(stall), 32'h0);
    end

`ifdef MSRV32_AHB_TIMEOUT_EN
    // Data-phase timeout after four wait cycles
    drive_req(1'b0, 32'h0000_8000, 32'h0, 4'b1111);
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t7_no_done", 32'(done), 32'h0);
    end
    @(negedge clk);
    check("t7_done", 32'(done), 32'h1);
    check("t7_err", 32'(err), 32'h1);
    check("t7_htrans", 32'(htrans), 32'h0);
    check("t7_stall", 32'(stall), 32'h0);
    req = 1'b0; ready = 1'b1;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
